vfpu_norm_round: RTL and testbench
==================================

Name: vfpu_norm_round

Overview:
- Normalize-and-round stage that directly consumes the leading-one detector (vfpu_lod instantiated inside, WIDTH = MANT_WIDTH+5).
- Accepts an unnormalized sign/exponent/extended mantissa from the vector FPU add/mul datapath.
- Shifts the mantissa to the hidden-bit position, adjusts the exponent and rounds to nearest-even.
- Emits an IEEE-754 result plus flags through a 2-stage valid/ready pipeline.

Parameters:
- EXP_WIDTH, 8, exponent field width.
- MANT_WIDTH, 23, stored fraction width.
- BIAS, 127, exponent bias; max finite exponent is 2**EXP_WIDTH-2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; invalidates both stages.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  stage can accept a beat.
- in_sign_i  in  1  result sign.
- in_exp_i  in  EXP_WIDTH+2  signed biased exponent, valid for the hidden-bit position.
- in_mant_i  in  MANT_WIDTH+5  bit[M+4] carry, [M+3] hidden, [M+2:3] fraction, [2] guard, [1] round, [0] sticky.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts.
- out_result_o  out  1+EXP_WIDTH+MANT_WIDTH  {sign, exp, fraction}.
- out_flags_o  out  4  {overflow, underflow, inexact, zero}.

Behaviour:
- Reset: both stage valids = 0, out_valid_o = 0, out_result_o = 0, out_flags_o = 0. in_ready_o = 1 once reset is released.
- Handshake:
  - s2_ready = ~s2_valid | out_ready_i.
  - in_ready_o = ~s1_valid | s2_ready.
  - A transfer occurs when valid & ready.
  - Stalled stages hold their data; out_result_o/out_flags_o are stable while out_valid_o & ~out_ready_i.
  - No combinational path from in_valid_i to out_valid_o.
  - Latency is 2 cycles with no stall; throughput is 1 beat/cycle with out_ready_i = 1.
- Stage 1 (normalize), registered on accept:
  - idx = LOD index counted from the MSB; no_ones → zero path.
  - idx == 0 (carry set): shift right by 1, OR the shifted-out bit into sticky, exp+1.
  - idx >= 1: shift left by idx-1, exp-(idx-1).
  - All arithmetic is in EXP_WIDTH+2 signed.
- Stage 2 (round), registered on accept:
  - round_up = G & (R | S | frac_lsb).
  - Fraction increment that overflows past the hidden bit: fraction = 0, exp+1.
  - inexact = G | R | S.
- Special cases, evaluated after rounding:
  - Zero mantissa: result {sign, 0, 0}; flags zero=1, others 0.
  - exp <= 0: flush to zero (no denormals). Result {sign, 0, 0}; underflow=1, zero=1, inexact=1.
  - exp >= 2**EXP_WIDTH-1: result {sign, all-ones, 0} (infinity); overflow=1, inexact=1.
- clear_i:
  - Drops s1_valid and s2_valid next cycle; data registers are don't-care.
  - Takes priority over a simultaneous input accept; the beat is discarded.
- Reset mid-operation: all in-flight beats are lost immediately; outputs return to reset values.

Test Plan:
- in_exp_i=127, in_mant_i=28'h4000000, sign 0 → 2 cycles later out_result_o=32'h3F800000, flags=4'b0000.
- in_mant_i=28'h8000000 (carry), exp 127 → 32'h40000000. in_mant_i=28'h0100000, exp 133 (left shift 6) → 32'h3F800000.
- Rounding:
  - 28'h4000004, exp 127 (tie, even lsb) → 32'h3F800000, inexact=1.
  - 28'h400000C → 32'h3F800002.
  - 28'h7FFFFFC → 32'h40000000 (carry-out of rounding).
- Specials:
  - in_mant_i=0, sign 1 → 32'h80000000, zero=1.
  - exp 254, mant 28'h8000000 → 32'h7F800000, overflow|inexact.
  - exp 3, mant 28'h0100000 → 32'h00000000, underflow|inexact|zero.
- Backpressure: stream 5 beats back-to-back with out_ready_i low for cycles 3-6 → in_ready_o drops once both stages are full, no beat lost or duplicated, order preserved, outputs stable while stalled.
- Flush/reset: assert clear_i with 2 beats in flight → no out_valid_o for them, next beat emerges with 2-cycle latency. Pulse rst_ni low mid-stream → out_valid_o=0 asynchronously, outputs zero.

Source files
------------

// File: rtl/vfpu_norm_round.sv
// vfpu_norm_round: normalize and round-to-nearest-even stage behind a 2-deep valid/ready pipe.
// Ports: clk_i / rst_ni      clock and asynchronous active-low reset
//        clear_i             synchronous flush of both stages
//        in_valid_i/in_ready_o, in_sign_i, in_exp_i, in_mant_i   unnormalized input beat
//        out_valid_o/out_ready_i, out_result_o {sign,exp,frac}, out_flags_o {ovf,unf,inexact,zero}

module vfpu_lod #(
    parameter int WIDTH = 28,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [IW-1:0]    idx_o,
    output logic             no_ones_o
);
    // Scanning upward lets the highest set bit win; index counts from the MSB.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++)
            if (in_i[i]) idx_o = IW'(WIDTH - 1 - i);
        no_ones_o = ~|in_i;
    end
endmodule

module vfpu_norm_round #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int BIAS       = 127
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              clear_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic                              in_sign_i,
    input  logic signed [EXP_WIDTH+1:0]       in_exp_i,
    input  logic [MANT_WIDTH+4:0]             in_mant_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [EXP_WIDTH+MANT_WIDTH:0]     out_result_o,
    output logic [3:0]                        out_flags_o
);
    localparam int W  = MANT_WIDTH + 5;
    localparam int EW = EXP_WIDTH + 2;
    localparam int IW = $clog2(W);
    localparam int RW = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_WIDTH) - 1);

    logic                 r_s1_valid, r_s1_sign, r_s1_zero, r_s2_valid;
    logic signed [EW-1:0] r_s1_exp;
    logic [W-2:0]         r_s1_mant;
    logic [RW-1:0]        r_result;
    logic [3:0]           r_flags;

    logic                 w_s2_ready, w_in_ready, w_in_fire, w_s1_fire;
    logic [IW-1:0]        w_idx, w_lshift;
    logic                 w_no_ones;
    logic [W-2:0]         w_norm_mant;
    logic signed [EW-1:0] w_norm_exp, w_rnd_exp;
    logic [MANT_WIDTH:0]  w_frac_sum;
    logic                 w_round_up, w_inexact, w_under, w_over;
    logic [RW-1:0]        w_result;
    logic [3:0]           w_flags;

    vfpu_lod #(.WIDTH(W)) u_lod (
        .in_i      (in_mant_i),
        .idx_o     (w_idx),
        .no_ones_o (w_no_ones)
    );

    assign w_s2_ready = ~r_s2_valid | out_ready_i;
    assign w_in_ready = ~r_s1_valid | w_s2_ready;
    assign w_in_fire  = in_valid_i & w_in_ready;
    assign w_s1_fire  = r_s1_valid & w_s2_ready;

    // Normalize: bit W-1 of the shifted mantissa is always zero, so only W-1 bits are kept.
    // A carry shifts right with both dropped low bits folded into sticky.
    always_comb begin
        w_lshift    = w_idx - IW'(1);
        w_norm_mant = (w_idx == '0) ? {in_mant_i[W-1:2], |in_mant_i[1:0]}
                                    : in_mant_i[W-2:0] << w_lshift;
        w_norm_exp  = (w_idx == '0) ? in_exp_i + EXP_ONE
                                    : in_exp_i - $signed(EW'(w_lshift));
    end

    // Round to nearest even on {G,R,S} = r_s1_mant[2:0]; a fraction carry-out bumps the exponent.
    always_comb begin
        w_round_up = r_s1_mant[2] & (r_s1_mant[1] | r_s1_mant[0] | r_s1_mant[3]);
        w_frac_sum = {1'b0, r_s1_mant[MANT_WIDTH+2:3]} + {{MANT_WIDTH{1'b0}}, w_round_up};
        w_rnd_exp  = r_s1_exp + $signed({{(EW-1){1'b0}}, w_frac_sum[MANT_WIDTH]});
        w_inexact  = |r_s1_mant[2:0];
        w_under    = w_rnd_exp <= EXP_ZERO;
        w_over     = w_rnd_exp >= EXP_MAX;
        w_result   = (r_s1_zero | w_under) ? {r_s1_sign, {(RW-1){1'b0}}}
                   : w_over ? {r_s1_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}}
                   : {r_s1_sign, w_rnd_exp[EXP_WIDTH-1:0], w_frac_sum[MANT_WIDTH-1:0]};
        w_flags    = r_s1_zero ? 4'b0001 : w_under ? 4'b0111 : w_over ? 4'b1010
                   : {2'b00, w_inexact, 1'b0};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_in_ready) r_s1_valid <= in_valid_i;
            if (w_in_fire) begin
                r_s1_sign <= in_sign_i;
                r_s1_zero <= w_no_ones;
                r_s1_exp  <= w_norm_exp;
                r_s1_mant <= w_norm_mant;
            end
            if (w_s2_ready) r_s2_valid <= r_s1_valid;
            if (w_s1_fire) begin
                r_result <= w_result;
                r_flags  <= w_flags;
            end
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = r_s2_valid;
    assign out_result_o = r_result;
    assign out_flags_o  = r_flags;
endmodule

// File: tb/tb_vfpu_norm_round.sv
// tb_vfpu_norm_round: randomized stream against an exact-arithmetic rounding model plus directed corners.
module tb_vfpu_norm_round;
    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_ready, in_sign, out_valid, out_ready;
    logic signed [9:0] in_exp;
    logic [27:0] in_mant;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    int vectors = 0, miscompares = 0;
    logic [35:0] q[$];
    bit    hold_v = 0, saw_full = 0, running = 0;
    logic [35:0] hold_val;

    always #5 clk = ~clk;

    vfpu_norm_round dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sign_i(in_sign),
        .in_exp_i(in_exp), .in_mant_i(in_mant),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_flags_o(out_flags)
    );

    // Exact value is mant * 2^(exp-127-26); place the leading one at bit 40 of a
    // 64-bit integer, keep 24 significant bits and round the 17-bit remainder to nearest even.
    function automatic logic [35:0] model(input logic s, input int e, input logic [27:0] m);
        longint x, keep, rem;
        int p, ex;
        bit inexact;
        if (m == 0) return {s, 31'd0, 4'b0001};
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        x = longint'(m) << (40 - p);
        keep = x >>> 17;
        rem = x & 64'h1FFFF;
        inexact = rem != 0;
        if (rem > 64'h10000 || (rem == 64'h10000 && keep[0])) keep++;
        ex = e + p - 26;
        if (keep == 64'h1000000) begin keep = keep >>> 1; ex++; end
        if (ex <= 0) return {s, 31'd0, 4'b0111};
        if (ex >= 255) return {s, 8'hFF, 23'd0, 4'b1010};
        return {s, ex[7:0], keep[22:0], 2'b00, inexact, 1'b0};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at %0t", name, act, want, $time);
        end
    endtask

    // Scoreboard: everything decided here concerns the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold_v = 0;
        end else begin
            if (!in_ready) saw_full = 1;
            if (out_valid && hold_v) check("stall_hold", {out_result, out_flags}, hold_val);
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("spurious_out", {out_result, out_flags}, 36'hX);
                else check("data", {out_result, out_flags}, q.pop_front());
            end
            hold_v = out_valid && !out_ready;
            hold_val = {out_result, out_flags};
            if (clear) begin
                q.delete();
                hold_v = 0;
            end else if (in_valid && in_ready) q.push_back(model(in_sign, int'(in_exp), in_mant));
        end
    end

    task automatic send(input logic s, input int e, input logic [27:0] m);
        bit acc;
        int n = 0;
        in_valid = 1; in_sign = s; in_exp = 10'(e); in_mant = m;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 200);
        if (!acc) check("send_timeout", 36'd0, 36'd1);
        in_valid = 0;
    endtask

    task automatic send_rand();
        logic [27:0] m = 28'($urandom) >> $urandom_range(0, 27);
        if ($urandom % 20 == 0) m = 0;
        send(1'($urandom), $urandom_range(0, 300) - 20, m);
    endtask

    initial begin
        rst_n = 0; clear = 0; in_valid = 0; in_sign = 0; in_exp = 0; in_mant = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1 check("rst_out", {31'd0, out_valid, out_result, out_flags}, 68'd0);
        rst_n = 1;
        #1 check("rst_ready", {35'd0, in_ready}, 36'd1);

        check("pin_one",   model(0, 127, 28'h4000000), {32'h3F800000, 4'b0000});
        check("pin_carry", model(0, 127, 28'h8000000), {32'h40000000, 4'b0000});
        check("pin_lsh6",  model(0, 133, 28'h0100000), {32'h3F800000, 4'b0000});
        check("pin_tie",   model(0, 127, 28'h4000004), {32'h3F800000, 4'b0010});
        check("pin_rup",   model(0, 127, 28'h400000C), {32'h3F800002, 4'b0010});
        check("pin_rcar",  model(0, 127, 28'h7FFFFFC), {32'h40000000, 4'b0010});
        check("pin_zero",  model(1, 127, 28'h0),       {32'h80000000, 4'b0001});
        check("pin_ovf",   model(0, 254, 28'h8000000), {32'h7F800000, 4'b1010});
        check("pin_unf",   model(0, 3,   28'h0100000), {32'h00000000, 4'b0111});

        @(posedge clk); #1;
        send(0, 127, 28'h4000000); send(0, 127, 28'h8000000); send(0, 133, 28'h0100000);
        send(0, 127, 28'h4000004); send(0, 127, 28'h400000C); send(0, 127, 28'h7FFFFFC);
        send(1, 127, 28'h0);       send(0, 254, 28'h8000000); send(0, 3, 28'h0100000);
        repeat (4) @(posedge clk); #1;

        // Backpressure: five beats while the sink stalls for four cycles.
        saw_full = 0;
        fork
            for (int i = 0; i < 5; i++) send_rand();
            begin repeat (2) @(posedge clk); #1 out_ready = 0; repeat (4) @(posedge clk); #1 out_ready = 1; end
        join
        repeat (5) @(posedge clk); #1;
        check("ready_drop", {35'd0, saw_full}, 36'd1);
        check("bp_drain", 36'(q.size()), 36'd0);

        // Flush: two beats parked, then clear together with a third beat that must be dropped.
        out_ready = 0;
        send(0, 127, 28'h4000000); send(1, 127, 28'h8000000);
        in_valid = 1; in_mant = 28'h400000C; clear = 1;
        @(posedge clk); #1 in_valid = 0; clear = 0; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); check("flushed", {35'd0, out_valid}, 36'd0);
        end
        @(posedge clk); #1;
        in_valid = 1; in_sign = 0; in_exp = 10'd127; in_mant = 28'h4000000;
        @(posedge clk); #1 in_valid = 0;
        @(negedge clk); check("lat1", {35'd0, out_valid}, 36'd0);
        @(negedge clk); check("lat2", {35'd0, out_valid}, 36'd1);
        @(posedge clk); #1;

        // Random stream with random backpressure, occasional clears and one mid-stream reset.
        running = 1;
        fork
            begin
                for (int i = 0; i < 600; i++) begin
                    if ($urandom % 4 == 0) begin @(posedge clk); #1; end
                    send_rand();
                end
                running = 0;
            end
            while (running) begin @(posedge clk); #1 out_ready = ($urandom % 4) != 0; end
            while (running) begin @(posedge clk); #1 clear = ($urandom % 60) == 0; end
            begin
                repeat (300) @(posedge clk);
                #3 rst_n = 0;
                #1 check("async_rst", {31'd0, out_valid, out_result, out_flags}, 68'd0);
                @(posedge clk); #1 rst_n = 1;
            end
        join
        clear = 0; out_ready = 1;
        repeat (6) @(posedge clk); #1;
        check("final_drain", {35'd0, q.size() == 0, 1'b0} >> 1, 36'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
